// File: rtl/risc_spm_pkg.sv
// risc_spm_pkg -- shared definitions for the RISC SPM core.
//   Holds the default word/address widths, the 4-bit opcode constants and
//   the control FSM state enum.  Imported by risc_spm_sram and risc_spm_core.
package risc_spm_pkg;

   localparam int WORD_SIZE_DEF = 16;
   localparam int ADDR_SIZE_DEF = 8;

   typedef enum logic [1:0] {
      ST_FETCH = 2'd0,
      ST_EXEC  = 2'd1,
      ST_HALT  = 2'd2
   } state_t;

   localparam logic [3:0] OP_NOP  = 4'h0;
   localparam logic [3:0] OP_ADD  = 4'h1;
   localparam logic [3:0] OP_LDI  = 4'h2;
   localparam logic [3:0] OP_SUB  = 4'h3;
   localparam logic [3:0] OP_AND  = 4'h4;
   localparam logic [3:0] OP_NOT  = 4'h5;
   localparam logic [3:0] OP_BRZ  = 4'h6;
   localparam logic [3:0] OP_HALT = 4'h7;
   localparam logic [3:0] OP_INC  = 4'h8;
   localparam logic [3:0] OP_BR   = 4'h9;
   localparam logic [3:0] OP_RD   = 4'hA;
   localparam logic [3:0] OP_WR   = 4'hB;
   localparam logic [3:0] OP_DEC  = 4'hC;
   localparam logic [3:0] OP_SHR  = 4'hD;
   localparam logic [3:0] OP_SHL  = 4'hE;

endpackage

// File: rtl/risc_spm_sram.sv
// risc_spm_sram -- single-port 2^ADDR_SIZE x WORD_SIZE memory.
//   Asynchronous read, synchronous write.  Contents are not reset; they are
//   preloaded from outside through the array "memory".
// Ports:
//   i_clk   : clock, write on rising edge
//   i_we    : write enable
//   i_addr  : shared read/write address
//   i_wdata : write data
//   o_rdata : combinational read data at i_addr
module risc_spm_sram
   import risc_spm_pkg::*;
#(
   parameter int WORD_SIZE = WORD_SIZE_DEF,
   parameter int ADDR_SIZE = ADDR_SIZE_DEF
) (
   input  logic                 i_clk,
   input  logic                 i_we,
   input  logic [ADDR_SIZE-1:0] i_addr,
   input  logic [WORD_SIZE-1:0] i_wdata,
   output logic [WORD_SIZE-1:0] o_rdata
);

   logic [WORD_SIZE-1:0] memory [2**ADDR_SIZE];

   assign o_rdata = memory[i_addr];

   // Plain always block: the array is also preloaded hierarchically from
   // outside, so it is not owned exclusively by this process.
   always @(posedge i_clk) begin
      if (i_we) begin
         memory[i_addr] <= i_wdata;
      end
   end

endmodule

// File: rtl/risc_spm_core.sv
// risc_spm_core -- simple stored-program machine: 4 registers, Z flag,
//   FETCH/EXEC/HALT control FSM, every instruction takes two cycles.
//   Instruction word: [15:12] opcode, [11:10] Rd, [9:8] Rs, [7:0] addr.
// Ports:
//   clk    : clock, all state changes on rising edge
//   rst    : synchronous active-low reset (memory is not cleared)
//   halted : high while the FSM sits in HALT
// Optional (macro RISC_SPM_DBG_EN):
//   dbg_pc, dbg_ir, dbg_r0 : current PC, IR and R0, straight from registers
module risc_spm_core
   import risc_spm_pkg::*;
#(
   parameter int WORD_SIZE = WORD_SIZE_DEF,
   parameter int ADDR_SIZE = ADDR_SIZE_DEF
) (
   input  logic                 clk,
   input  logic                 rst,
`ifdef RISC_SPM_DBG_EN
   output logic [ADDR_SIZE-1:0] dbg_pc,
   output logic [WORD_SIZE-1:0] dbg_ir,
   output logic [WORD_SIZE-1:0] dbg_r0,
`endif
   output logic                 halted
);

   state_t               r_state;
   logic [ADDR_SIZE-1:0] r_pc;
   logic [WORD_SIZE-1:0] r_ir;
   logic [WORD_SIZE-1:0] r_regs [4];
   logic                 r_z;
   logic                 r_halted;

   logic [3:0]           w_opcode;
   logic [1:0]           w_rd;
   logic [1:0]           w_rs;
   logic [ADDR_SIZE-1:0] w_addr;
   logic [WORD_SIZE-1:0] w_rd_val;
   logic [WORD_SIZE-1:0] w_rs_val;
   logic [ADDR_SIZE-1:0] w_pc_inc;
   logic [ADDR_SIZE-1:0] w_mem_addr;
   logic                 w_mem_we;
   logic [WORD_SIZE-1:0] w_mem_rdata;
   logic [WORD_SIZE-1:0] w_alu_res;
   logic                 w_reg_we;
   logic                 w_z_upd;

   assign w_opcode = r_ir[WORD_SIZE-1 -: 4];
   assign w_rd     = r_ir[WORD_SIZE-5 -: 2];
   assign w_rs     = r_ir[WORD_SIZE-7 -: 2];
   assign w_addr   = r_ir[ADDR_SIZE-1:0];
   assign w_rd_val = r_regs[w_rd];
   assign w_rs_val = r_regs[w_rs];
   assign w_pc_inc = r_pc + 1'b1;
   assign halted   = r_halted;

`ifdef RISC_SPM_DBG_EN
   assign dbg_pc = r_pc;
   assign dbg_ir = r_ir;
   assign dbg_r0 = r_regs[0];
`endif

   // One memory port: PC addresses it except when RD/WR execute.  The write
   // is gated by rst so a reset edge never commits a pending WR.
   always_comb begin
      w_mem_addr = r_pc;
      w_mem_we   = 1'b0;
      if (r_state == ST_EXEC) begin
         if (w_opcode == OP_RD || w_opcode == OP_WR) begin
            w_mem_addr = w_addr;
         end
         if (w_opcode == OP_WR) begin
            w_mem_we = rst;
         end
      end
   end

   risc_spm_sram #(
      .WORD_SIZE (WORD_SIZE),
      .ADDR_SIZE (ADDR_SIZE)
   ) M2_SRAM (
      .i_clk   (clk),
      .i_we    (w_mem_we),
      .i_addr  (w_mem_addr),
      .i_wdata (w_rs_val),
      .o_rdata (w_mem_rdata)
   );

   // Result, register write enable and Z update for the instruction in IR.
   always_comb begin
      w_alu_res = '0;
      w_reg_we  = 1'b0;
      w_z_upd   = 1'b0;
      unique case (w_opcode)
         OP_ADD: begin w_alu_res = w_rd_val + w_rs_val; w_reg_we = 1'b1; w_z_upd = 1'b1; end
         OP_SUB: begin w_alu_res = w_rd_val - w_rs_val; w_reg_we = 1'b1; w_z_upd = 1'b1; end
         OP_AND: begin w_alu_res = w_rd_val & w_rs_val; w_reg_we = 1'b1; w_z_upd = 1'b1; end
         OP_NOT: begin w_alu_res = ~w_rs_val;           w_reg_we = 1'b1; w_z_upd = 1'b1; end
         OP_INC: begin w_alu_res = w_rd_val + 1'b1;     w_reg_we = 1'b1; w_z_upd = 1'b1; end
         OP_DEC: begin w_alu_res = w_rd_val - 1'b1;     w_reg_we = 1'b1; w_z_upd = 1'b1; end
         OP_SHR: begin w_alu_res = {1'b0, w_rd_val[WORD_SIZE-1:1]}; w_reg_we = 1'b1; w_z_upd = 1'b1; end
         OP_SHL: begin w_alu_res = {w_rd_val[WORD_SIZE-2:0], 1'b0}; w_reg_we = 1'b1; w_z_upd = 1'b1; end
         OP_LDI, OP_RD: begin w_alu_res = w_mem_rdata; w_reg_we = 1'b1; end
         default: begin w_alu_res = '0; end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state  <= ST_FETCH;
         r_pc     <= '0;
         r_ir     <= '0;
         r_z      <= 1'b0;
         r_halted <= 1'b0;
         for (int i = 0; i < 4; i++) begin
            r_regs[i] <= '0;
         end
      end else begin
         unique case (r_state)
            ST_FETCH: begin
               r_ir    <= w_mem_rdata;
               r_pc    <= w_pc_inc;
               r_state <= ST_EXEC;
            end
            ST_EXEC: begin
               if (w_reg_we) begin
                  r_regs[w_rd] <= w_alu_res;
               end
               if (w_z_upd) begin
                  r_z <= (w_alu_res == '0);
               end
               // LDI consumes its operand word, so PC steps past it.
               if (w_opcode == OP_LDI) begin
                  r_pc <= w_pc_inc;
               end else if (w_opcode == OP_BR || (w_opcode == OP_BRZ && r_z)) begin
                  r_pc <= w_addr;
               end
               if (w_opcode == OP_HALT) begin
                  r_state  <= ST_HALT;
                  r_halted <= 1'b1;
               end else begin
                  r_state <= ST_FETCH;
               end
            end
            ST_HALT: begin
               r_state  <= ST_HALT;
               r_halted <= 1'b1;
            end
            default: begin
               r_state <= ST_FETCH;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_risc_spm_core.sv
// tb_risc_spm_core -- directed program bench for risc_spm_core.
module tb_risc_spm_core;
   import risc_spm_pkg::*;

   logic clk;
   logic rst;
   logic halted;

   int checks = 0;
   int errors = 0;

   risc_spm_core dut (
      .clk    (clk),
      .rst    (rst),
      .halted (halted)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance n rising edges, then step 1 time unit off the edge.
   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic load(input int addr, input logic [15:0] data);
      dut.M2_SRAM.memory[addr] = data;
   endtask

   task automatic chk_regs(input string tag, input logic [15:0] e0, input logic [15:0] e1,
                           input logic [15:0] e2, input logic [15:0] e3);
      chk({tag, "_r0"}, 32'(dut.r_regs[0]), 32'(e0));
      chk({tag, "_r1"}, 32'(dut.r_regs[1]), 32'(e1));
      chk({tag, "_r2"}, 32'(dut.r_regs[2]), 32'(e2));
      chk({tag, "_r3"}, 32'(dut.r_regs[3]), 32'(e3));
   endtask

   // LDI R0,1458 ; INC R0 ; SHR R0 ; HALT
   task automatic run_prog1(input string tag);
      cycles(2);
      chk({tag, "_ldi_r0"}, 32'(dut.r_regs[0]), 32'd1458);
      chk({tag, "_ldi_pc"}, 32'(dut.r_pc), 32'd2);
      cycles(2);
      chk({tag, "_inc_r0"}, 32'(dut.r_regs[0]), 32'd1459);
      cycles(2);
      chk({tag, "_shr_r0"}, 32'(dut.r_regs[0]), 32'h02D9);
      chk({tag, "_shr_z"}, 32'(dut.r_z), 32'd0);
      cycles(1);
      chk({tag, "_halt_early"}, 32'(halted), 32'd0);
      cycles(1);
      chk({tag, "_halted"}, 32'(halted), 32'd1);
      chk({tag, "_halt_pc"}, 32'(dut.r_pc), 32'd5);
      cycles(5);
      chk({tag, "_sticky_halted"}, 32'(halted), 32'd1);
      chk({tag, "_sticky_pc"}, 32'(dut.r_pc), 32'd5);
      chk({tag, "_sticky_r0"}, 32'(dut.r_regs[0]), 32'h02D9);
      chk({tag, "_sticky_state"}, 32'(dut.r_state), 32'(ST_HALT));
   endtask

   initial begin
      rst = 1'b0;
      cycles(2);
      // reset state
      chk("rst_pc", 32'(dut.r_pc), 32'd0);
      chk("rst_ir", 32'(dut.r_ir), 32'd0);
      chk("rst_z", 32'(dut.r_z), 32'd0);
      chk("rst_halted", 32'(halted), 32'd0);
      chk("rst_state", 32'(dut.r_state), 32'(ST_FETCH));
      chk_regs("rst", 16'h0, 16'h0, 16'h0, 16'h0);

      // basic program, then reset from HALT and rerun
      load(0, 16'h2000); load(1, 16'd1458); load(2, 16'h8000); load(3, 16'hD000); load(4, 16'h7000);
      rst = 1'b1;
      run_prog1("p1");
      rst = 1'b0;
      cycles(1);
      chk("rehalt_halted", 32'(halted), 32'd0);
      chk("rehalt_pc", 32'(dut.r_pc), 32'd0);
      chk_regs("rehalt", 16'h0, 16'h0, 16'h0, 16'h0);
      chk("rehalt_mem1", 32'(dut.M2_SRAM.memory[1]), 32'd1458);
      rst = 1'b1;
      run_prog1("p1b");

      // INC wraps to zero and sets Z; NOP keeps Z
      rst = 1'b0;
      load(0, 16'h2400); load(1, 16'hFFFF); load(2, 16'h8400); load(3, 16'h0000); load(4, 16'h7000);
      cycles(1);
      rst = 1'b1;
      cycles(2);
      chk("wrap_ldi_r1", 32'(dut.r_regs[1]), 32'hFFFF);
      chk("wrap_ldi_z", 32'(dut.r_z), 32'd0);
      cycles(2);
      chk("wrap_inc_r1", 32'(dut.r_regs[1]), 32'h0000);
      chk("wrap_inc_z", 32'(dut.r_z), 32'd1);
      cycles(2);
      chk("wrap_nop_z", 32'(dut.r_z), 32'd1);
      cycles(2);
      chk("wrap_halted", 32'(halted), 32'd1);

      // BR to FE, LDI at FE fetches operand at FF, PC wraps to 0
      rst = 1'b0;
      load(0, 16'h90FE); load(254, 16'h2000); load(255, 16'hABCD);
      cycles(1);
      rst = 1'b1;
      cycles(2);
      chk("pcwrap_br_pc", 32'(dut.r_pc), 32'hFE);
      cycles(2);
      chk("pcwrap_ldi_r0", 32'(dut.r_regs[0]), 32'hABCD);
      chk("pcwrap_ldi_pc", 32'(dut.r_pc), 32'h00);

      // countdown loop: LDI R0,5 ; DEC R0 ; BRZ 6 ; BR 2 ; - ; HALT
      rst = 1'b0;
      load(0, 16'h2000); load(1, 16'h0005); load(2, 16'hC000); load(3, 16'h6006);
      load(4, 16'h9002); load(5, 16'h0000); load(6, 16'h7000);
      cycles(1);
      rst = 1'b1;
      cycles(4);
      chk("loop_first_dec_r0", 32'(dut.r_regs[0]), 32'd4);
      chk("loop_first_dec_z", 32'(dut.r_z), 32'd0);
      cycles(27);
      chk("loop_not_yet_halted", 32'(halted), 32'd0);
      cycles(1);
      chk("loop_halted", 32'(halted), 32'd1);
      chk("loop_r0", 32'(dut.r_regs[0]), 32'd0);
      chk("loop_z", 32'(dut.r_z), 32'd1);
      chk("loop_pc", 32'(dut.r_pc), 32'd7);

      // LDI R2,1234 ; WR [80]=R2 ; RD R3,[80] ; HALT
      rst = 1'b0;
      load(0, 16'h2800); load(1, 16'h1234); load(2, 16'hB280); load(3, 16'hAC80); load(4, 16'h7000);
      load(128, 16'h0000);
      cycles(1);
      rst = 1'b1;
      cycles(4);
      chk("wr_mem80", 32'(dut.M2_SRAM.memory[128]), 32'h1234);
      cycles(2);
      chk("rd_r3", 32'(dut.r_regs[3]), 32'h1234);
      chk("rd_z_untouched", 32'(dut.r_z), 32'd0);
      cycles(2);
      chk("wrrd_halted", 32'(halted), 32'd1);

      // ALU mix: ADD, AND, SUB to zero, NOT, SHL, SUB wrap
      rst = 1'b0;
      load(0, 16'h2000); load(1, 16'h00F0); load(2, 16'h2400); load(3, 16'h0F0F);
      load(4, 16'h1100); load(5, 16'h4400); load(6, 16'h3500); load(7, 16'h5900);
      load(8, 16'hE800); load(9, 16'h3E00); load(10, 16'h7000);
      cycles(1);
      rst = 1'b1;
      cycles(6);
      chk("alu_add_r0", 32'(dut.r_regs[0]), 32'h0FFF);
      cycles(2);
      chk("alu_and_r1", 32'(dut.r_regs[1]), 32'h0F0F);
      cycles(2);
      chk("alu_sub_r1", 32'(dut.r_regs[1]), 32'h0000);
      chk("alu_sub_z", 32'(dut.r_z), 32'd1);
      cycles(2);
      chk("alu_not_r2", 32'(dut.r_regs[2]), 32'hFFFF);
      chk("alu_not_z", 32'(dut.r_z), 32'd0);
      cycles(4);
      chk_regs("alu_end", 16'h0FFF, 16'h0000, 16'hFFFE, 16'h0002);
      cycles(2);
      chk("alu_halted", 32'(halted), 32'd1);

      // illegal opcode Fxxx executes as NOP
      rst = 1'b0;
      load(0, 16'hF123); load(1, 16'h7000);
      cycles(1);
      rst = 1'b1;
      cycles(3);
      chk("ill_not_halted", 32'(halted), 32'd0);
      cycles(1);
      chk("ill_halted", 32'(halted), 32'd1);
      chk("ill_pc", 32'(dut.r_pc), 32'd2);
      chk("ill_z", 32'(dut.r_z), 32'd0);
      chk_regs("ill", 16'h0, 16'h0, 16'h0, 16'h0);

      // reset landing on a WR's EXEC edge must suppress the write
      rst = 1'b0;
      load(0, 16'hB240); load(64, 16'h5555);
      cycles(1);
      rst = 1'b1;
      cycles(1);
      rst = 1'b0;
      cycles(1);
      chk("abort_mem40", 32'(dut.M2_SRAM.memory[64]), 32'h5555);
      chk("abort_pc", 32'(dut.r_pc), 32'd0);
      chk("abort_ir", 32'(dut.r_ir), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/risc_spm_core.md
RISC_SPM_CORE -- requirements
Module: risc_spm_core

Interface
REQ-001 SHALL have parameter WORD_SIZE, default 16: data, instruction and register width.
REQ-002 SHALL have parameter ADDR_SIZE, default 8: PC and memory address width, giving 256 words.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state changes on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-low.
REQ-005 SHALL have port halted, output, 1 bit: high while the control FSM is in HALT.

Function
REQ-006 SHALL use instruction format [15:12] opcode, [11:10] Rd, [9:8] Rs, [7:0] addr; registers are R0..R3, where R0 is "RA".
REQ-007 SHALL decode opcodes as follows:
- 0 NOP
- 1 ADD: Rd=Rd+Rs
- 2 LDI: Rd=mem[PC], PC+1 (two-word instruction)
- 3 SUB: Rd=Rd-Rs
- 4 AND: Rd=Rd&Rs
- 5 NOT: Rd=~Rs
- 6 BRZ: if Z, PC=addr
- 7 HALT
- 8 INC: Rd=Rd+1
- 9 BR: PC=addr
- A RD: Rd=mem[addr]
- B WR: mem[addr]=Rs
- C DEC: Rd=Rd-1
- D SHR: logical right shift by 1, MSB<=0
- E SHL: left shift by 1, LSB<=0
- F: illegal, executes as NOP
REQ-008 SHALL implement the control FSM with states FETCH, EXEC and HALT.
REQ-009 In FETCH, SHALL load IR<=mem[PC] and PC<=PC+1, then go to EXEC.
REQ-010 In EXEC, SHALL perform the decoded operation, then go to FETCH, or to HALT for opcode 7.
REQ-011 SHALL execute every instruction, including LDI, in exactly 2 cycles (FETCH + EXEC).
REQ-012 HALT SHALL be sticky: PC, registers and memory frozen until rst=0.
REQ-013 Arithmetic SHALL be modulo 2^16 with no trap; ADD/INC/SUB/DEC wrap.
REQ-014 Z flag SHALL update only on ADD, SUB, AND, NOT, INC, DEC, SHR and SHL, set iff the 16-bit result is 0; other instructions SHALL leave Z unchanged.
REQ-015 PC SHALL wrap 255->0 on increment, including the LDI operand fetch at address 255.
REQ-016 Memory read SHALL be asynchronous (combinational) and memory write synchronous.
REQ-017 SHALL make at most one memory access per cycle.
REQ-018 WR then RD to the same address in consecutive instructions SHALL return the written value.
REQ-019 BRZ/BR SHALL take effect so that the next FETCH reads mem[addr].

Reset
REQ-020 When rst=0 at a rising clk edge: PC=0, IR=0, R0..R3=0, Z=0, state=FETCH, halted=0.
REQ-021 Reset SHALL NOT clear memory contents; memory is initialised externally.
REQ-022 Reset mid-instruction (any state, including HALT) SHALL abort it with no register or memory write in that cycle.
REQ-023 The first FETCH SHALL occur on the first rising edge with rst=1.

Configuration
REQ-024 With RISC_SPM_DBG_EN defined, SHALL add outputs dbg_pc[7:0] (current PC), dbg_ir[15:0] (IR) and dbg_r0[15:0] (R0), all combinational from registers, reset values 0.
REQ-025 Without RISC_SPM_DBG_EN, these ports SHALL be absent; functional behaviour is identical.

Structure
REQ-026 Package risc_spm_pkg SHALL hold WORD_SIZE/ADDR_SIZE defaults, opcode constants and the FSM state enum.
REQ-027 Memory SHALL be sub-module risc_spm_sram: 256x16, array named memory, instantiated as M2_SRAM, so benches preload via hierarchical path M2_SRAM.memory[k].
REQ-028 Datapath (register file, ALU, PC, IR) and control FSM SHALL live in risc_spm_core.

Verification
REQ-029 Program mem[0..4]=2000h, 1458, 8000h, D000h, 7000h, reset released -> R0 reads 1458, then 1459, then 729 (02D9h); halted=1 after 8 executing cycles; PC=5 and stays.
REQ-030 LDI R1,FFFFh; INC R1 -> R1=0000h, Z=1; next NOP leaves Z=1.
REQ-031 LDI R0,5; DEC R0 looped with BRZ exit/BR back -> exits after 5 iterations, R0=0.
REQ-032 LDI R2,1234h; WR mem[80h]=R2; RD R3,80h -> mem[80h]=1234h, R3=1234h.
REQ-033 Reset asserted during a halted run -> halted=0, PC=0, all registers 0; memory unchanged; program reruns identically.
REQ-034 Opcode Fxxx at address 0 followed by HALT -> no register change, halted after 4 cycles.
